serail_ctrl: RTL and testbench
==============================

SERAIL_CTRL -- requirements
Module: serail_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 434, clock cycles per UART bit; legal 4..65535.
REQ-002 SHALL have parameter DEPTH, default 4, entries per FIFO; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port serail_ce_i, input, 1, bus request from CPU.
REQ-006 SHALL have port serail_we_i, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port serail_addr_i, input, 2, register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-008 SHALL have port serail_data_i, input, 32, write data; only [7:0] used.
REQ-009 SHALL have port serail_data_o, output, 32, read data, zero-extended.
REQ-010 SHALL have port serail_ready_o, output, 1, transaction-complete strobe.
REQ-011 SHALL have port rxd, input, 1, asynchronous UART receive line, idle high.
REQ-012 SHALL have port txd, output, 1, UART transmit line, idle high.
REQ-013 SHALL have port com_int_o, output, 1, level interrupt toward CPU int_i.

Function
REQ-014 Bus FSM SHALL have states IDLE and ACK; in IDLE with serail_ce_i=1 it samples we/addr/data and moves to ACK.
REQ-015 In ACK serail_ready_o SHALL be 1 for exactly that one cycle, then return to IDLE; serail_ce_i ignored in ACK; back-to-back accesses complete every 2 cycles.
REQ-016 serail_data_o SHALL be valid while serail_ready_o=1 and 0 otherwise.
REQ-017 Write DATA SHALL push [7:0] into TX FIFO; if full, byte dropped, ready still asserted.
REQ-018 Read DATA SHALL return and pop RX FIFO head; if empty, return 0, no pop.
REQ-019 Read STATUS SHALL return {27'b0, frame_err, overrun, tx_busy, rx_avail, tx_space}; tx_space = TX FIFO not full; rx_avail = RX FIFO not empty; tx_busy = TX FSM not IDLE or TX FIFO not empty.
REQ-020 Read STATUS SHALL clear overrun and frame_err at the ACK cycle; write STATUS has no effect.
REQ-021 CTRL bit0 SHALL be rx_ie (read/write); other bits read 0; address 3 reads 0, writes ignored.
REQ-022 TX FSM SHALL have states IDLE, START, DATA, STOP; leaves IDLE when TX FIFO non-empty, popping one byte.
REQ-023 TX SHALL send 8N1, LSB first, each bit exactly DIV cycles; txd=1 in IDLE; next byte may start the cycle after STOP ends (no idle gap).
REQ-024 rxd SHALL pass a 2-flop synchronizer before use.
REQ-025 RX FSM SHALL have states IDLE, START, DATA, STOP; synchronized falling edge in IDLE enters START.
REQ-026 RX SHALL sample at DIV/2 (integer) cycles into START, then every DIV cycles; start sample 1 aborts to IDLE with no flag.
REQ-027 Stop sample 0 SHALL set frame_err and discard the byte; stop sample 1 pushes byte into RX FIFO.
REQ-028 Push into full RX FIFO SHALL drop the byte and set overrun; pop and push in same cycle with FIFO full SHALL both succeed, no overrun.
REQ-029 After stop sample RX SHALL return to IDLE and accept a new falling edge on the next cycle.
REQ-030 com_int_o SHALL equal rx_ie AND rx_avail, registered.
REQ-031 Flag set (overrun/frame_err) and STATUS-read clear in the same cycle SHALL leave the flag set.

Reset
REQ-032 On rst=1: FSMs to IDLE, FIFOs empty, flags and rx_ie 0, serail_ready_o 0, serail_data_o 0, txd 1, com_int_o 0, synchronizer 1s; applies mid-frame, txd=1 the cycle after rst sampled.

Verification (DIV=4, DEPTH=4)
REQ-033 Write DATA 0x55 -> txd: 0 for 4 cycles, bits 1,0,1,0,1,0,1,0 each 4 cycles, 1 for 4 cycles; ready one cycle after ce.
REQ-034 Drive rxd frame 0xA3, valid stop -> STATUS reads 0x03; DATA reads 0x000000A3; STATUS then 0x01.
REQ-035 Set CTRL=1, receive 0x41 -> com_int_o rises; DATA read -> com_int_o falls.
REQ-036 Receive 5 bytes, no reads -> STATUS=0x0B; first 4 bytes returned in order, 5th lost; second STATUS read shows overrun 0.
REQ-037 rxd frame with stop bit 0 -> STATUS=0x11, RX FIFO empty.
REQ-038 Write 6 bytes back-to-back -> 4 queued plus 1 in flight transmitted, 6th dropped; rst asserted mid-byte -> txd=1 next cycle, STATUS=0x01.

Source files
------------

// File: rtl/serail_ctrl.sv
// Memory-mapped UART: CPU bus slave (DATA/STATUS/CTRL), TX and RX FIFOs,
// 8N1 transmitter and receiver, and a level receive interrupt.
module serail_ctrl #(
    parameter int DIV   = 434,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serail_ce_i,
    input  logic        serail_we_i,
    input  logic [1:0]  serail_addr_i,
    input  logic [31:0] serail_data_i,
    output logic [31:0] serail_data_o,
    output logic        serail_ready_o,
    input  logic        rxd,
    output logic        txd,
    output logic        com_int_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} line_state_t;

    bus_state_t  bus_state, bus_next;
    line_state_t tx_state, tx_next, rx_state, rx_next;

    logic        req_we;
    logic [1:0]  req_addr;
    logic [7:0]  req_data;
    logic        ack, wr_data, wr_ctrl, rd_data, rd_status;
    logic        unused_data_hi;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0]   tx_level;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_busy, tx_bit_end;
    logic [15:0]   tx_tick;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_level;
    logic          rx_full, rx_empty, rx_push, rx_pop;
    logic          rx_s1, rx_s2, rx_prev, rx_sample, rx_stop_ok, frame_set, overrun_set;
    logic [15:0]   rx_tick;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    logic overrun, frame_err, rx_ie;

    assign unused_data_hi = ^serail_data_i[31:8];

    // ---------------- bus slave ----------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (serail_ce_i) bus_next = BUS_ACK;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state <= BUS_IDLE;
            req_we    <= 1'b0;
            req_addr  <= 2'd0;
            req_data  <= 8'd0;
        end else begin
            bus_state <= bus_next;
            if (bus_state == BUS_IDLE && serail_ce_i) begin
                req_we   <= serail_we_i;
                req_addr <= serail_addr_i;
                req_data <= serail_data_i[7:0];
            end
        end
    end

    assign ack            = (bus_state == BUS_ACK);
    assign serail_ready_o = ack;
    assign wr_data   = ack &  req_we & (req_addr == 2'd0);
    assign wr_ctrl   = ack &  req_we & (req_addr == 2'd2);
    assign rd_data   = ack & ~req_we & (req_addr == 2'd0);
    assign rd_status = ack & ~req_we & (req_addr == 2'd1);

    always_comb begin
        serail_data_o = 32'd0;
        if (ack && !req_we) begin
            case (req_addr)
                2'd0:    if (!rx_empty) serail_data_o[7:0] = rx_mem[rx_rp];
                2'd1:    serail_data_o[4:0] = {frame_err, overrun, tx_busy, ~rx_empty, ~tx_full};
                2'd2:    serail_data_o[0] = rx_ie;
                default: serail_data_o = 32'd0;
            endcase
        end
    end

    // ---------------- FIFOs ----------------
    assign tx_full  = (tx_level == FULL_LVL);
    assign tx_empty = (tx_level == '0);
    assign tx_push  = wr_data & ~tx_full;
    assign rx_full  = (rx_level == FULL_LVL);
    assign rx_empty = (rx_level == '0);
    assign rx_pop   = rd_data & ~rx_empty;
    // A full RX FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_push     = rx_stop_ok & (~rx_full | rx_pop);
    assign overrun_set = rx_stop_ok & rx_full & ~rx_pop;

    // NOTE: FIFO storage is deliberately not reset; the levels alone define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= req_data;
        if (rx_push) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_level <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_level <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LVL_ONE;
                2'b01:   tx_level <= tx_level - LVL_ONE;
                default: ;
            endcase
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LVL_ONE;
                2'b01:   rx_level <= rx_level - LVL_ONE;
                default: ;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    assign tx_bit_end = (tx_tick == BIT_LAST);
    assign tx_busy    = (tx_state != S_IDLE) | ~tx_empty;

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        txd     = 1'b1;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
            S_START: begin txd = 1'b0; if (tx_bit_end) tx_next = S_DATA; end
            S_DATA:  begin txd = tx_shift[0]; if (tx_bit_end && tx_bit == 3'd7) tx_next = S_STOP; end
            S_STOP:  if (tx_bit_end) begin
                         tx_next = tx_empty ? S_IDLE : S_START;
                         tx_pop  = ~tx_empty;
                     end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_tick  <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'hff;
        end else begin
            tx_state <= tx_next;
            tx_tick  <= (tx_state == S_IDLE || tx_bit_end) ? 16'd0 : tx_tick + 16'd1;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rp];
                tx_bit   <= 3'd0;
            end else if (tx_state == S_DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    always_comb begin
        rx_next    = rx_state;
        rx_sample  = 1'b0;
        rx_stop_ok = 1'b0;
        frame_set  = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
            S_START: if (rx_tick == HALF_LAST) begin
                         rx_sample = 1'b1;
                         rx_next   = rx_s2 ? S_IDLE : S_DATA;
                     end
            S_DATA:  if (rx_tick == BIT_LAST) begin
                         rx_sample = 1'b1;
                         if (rx_bit == 3'd7) rx_next = S_STOP;
                     end
            S_STOP:  if (rx_tick == BIT_LAST) begin
                         rx_sample  = 1'b1;
                         rx_next    = S_IDLE;
                         rx_stop_ok = rx_s2;
                         frame_set  = ~rx_s2;
                     end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_tick  <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            rx_tick  <= (rx_state == S_IDLE || rx_sample) ? 16'd0 : rx_tick + 16'd1;
            if (rx_state == S_IDLE) begin
                rx_bit <= 3'd0;
            end else if (rx_state == S_DATA && rx_sample) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- flags, control, interrupt ----------------
    // A flag raised in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_ie     <= 1'b0;
            com_int_o <= 1'b0;
        end else begin
            overrun   <= overrun_set | (overrun   & ~rd_status);
            frame_err <= frame_set   | (frame_err & ~rd_status);
            if (wr_ctrl) rx_ie <= req_data[0];
            com_int_o <= rx_ie & ~rx_empty;
        end
    end

endmodule

// File: tb/tb_serail_ctrl.sv
// Self-checking bench for serail_ctrl: bus accesses, TX line decoding and
// RX frame injection compared against a queue-based model of the UART.
module tb_serail_ctrl;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata_o;
    logic        ready, txd, com_int;
    logic        rxd = 1'b1;

    always #5 clk = ~clk;

    serail_ctrl #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .serail_ce_i(ce), .serail_we_i(we), .serail_addr_i(addr),
        .serail_data_i(wdata), .serail_data_o(rdata_o), .serail_ready_o(ready),
        .rxd(rxd), .txd(txd), .com_int_o(com_int)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] rx_model[$];
    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];
    logic       m_ovr = 1'b0, m_fe = 1'b0, m_ie = 1'b0;
    bit         mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input bit space);
        return {27'd0, m_fe, m_ovr, busy, rx_model.size() != 0, space};
    endfunction

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        ce = 1'b1; we = w; addr = a; wdata = d;
        tick();
        check("ready_ack", {31'd0, ready}, 32'd1);
        r = rdata_o;
        if (w) check("data_on_write", r, 32'd0);
        ce = 1'b0; we = 1'b0; wdata = 32'd0;
        tick();
        check("ready_idle", {31'd0, ready}, 32'd0);
        check("data_idle", rdata_o, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic rd_status(input string tag, input bit busy, input bit space);
        rd(tag, 2'd1, exp_status(busy, space));
        m_fe  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] e;
        e = 32'd0;
        if (rx_model.size() != 0) e = {24'd0, rx_model.pop_front()};
        rd(tag, 2'd0, e);
    endtask

    // Drives one 8N1 frame on rxd and updates the model with its outcome.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) tick();
        end
        rxd = stop;
        repeat (DIV) tick();
        rxd = 1'b1;
        repeat (DIV) tick();
        if (!stop)                      m_fe = 1'b1;
        else if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else                            m_ovr = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        int t;
        t = 0;
        while (tx_got.size() < n && t < 2000) begin
            tick();
            t++;
        end
        check("tx_count", tx_got.size(), n);
        for (int i = 0; i < n && i < tx_got.size() && i < tx_exp.size(); i++)
            check("tx_byte", {24'd0, tx_got[i]}, {24'd0, tx_exp[i]});
        tx_got.delete();
        tx_exp.delete();
    endtask

    // TX line decoder: samples each bit in its middle.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        logic       sb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && txd === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                sb = txd;
                check("tx_stop_bit", {31'd0, sb}, 32'd1);
                tx_got.push_back(b);
            end
            prev = txd;
        end
    end

    initial begin : main
        logic [7:0]  d;
        logic [39:0] got_v, exp_v;
        int          t, fb, nt, nf, nr;
        logic        stop, seen_low;

        // Reset state
        repeat (3) tick();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data", rdata_o, 32'd0);
        check("rst_int", {31'd0, com_int}, 32'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        rd_status("status_after_rst", 1'b0, 1'b1);

        // Exact waveform of one transmitted byte
        d = 8'h55;
        wr(2'd0, {24'd0, d});
        tx_exp.push_back(d);
        t = 0;
        @(negedge clk);
        while (txd !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 40; i++) begin
            fb = i / DIV;
            exp_v[i] = (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : d[fb - 1];
            got_v[i] = txd;
            @(negedge clk);
        end
        check("tx_wave_55", {24'd0, got_v[39:32]}, {24'd0, exp_v[39:32]});
        check("tx_wave_55_lo", got_v[31:0], exp_v[31:0]);
        check("tx_idle_after", {31'd0, txd}, 32'd1);
        @(posedge clk); #1;
        wait_tx(1);

        // Single received frame
        send_frame(8'hA3, 1'b1);
        rd_status("status_rx_avail", 1'b0, 1'b1);
        rd_data("data_a3");
        rd_status("status_rx_empty", 1'b0, 1'b1);

        // One-cycle glitch aborts in START without any flag
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (12) tick();
        rd_status("status_glitch", 1'b0, 1'b1);

        // Interrupt enable and CTRL/reserved registers
        wr(2'd2, 32'hFFFF_FFFF);
        m_ie = 1'b1;
        rd("ctrl_read", 2'd2, 32'd1);
        wr(2'd3, 32'h0000_00FF);
        rd("reserved_read", 2'd3, 32'd0);
        send_frame(8'h41, 1'b1);
        check("int_high", {31'd0, com_int}, 32'd1);
        rd_data("data_41");
        tick();
        check("int_low", {31'd0, com_int}, 32'd0);

        // Overrun: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
        wr(2'd1, 32'hFF);
        rd_status("status_overrun", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) rd_data("data_overrun_seq");
        rd_status("status_overrun_clr", 1'b0, 1'b1);

        // Framing error
        send_frame(8'($urandom), 1'b0);
        rd_status("status_frame_err", 1'b0, 1'b1);
        rd_data("data_after_ferr");
        rd_status("status_ferr_clr", 1'b0, 1'b1);

        // Randomized mixed traffic
        for (int round = 0; round < 8; round++) begin
            m_ie = 1'($urandom);
            wr(2'd2, {31'd0, m_ie});
            nt = $urandom_range(0, 2);
            for (int i = 0; i < nt; i++) begin
                d = 8'($urandom);
                wr(2'd0, {24'd0, d});
                tx_exp.push_back(d);
            end
            nf = $urandom_range(1, 5);
            for (int i = 0; i < nf; i++) begin
                stop = ($urandom_range(0, 5) != 0);
                send_frame(8'($urandom), stop);
            end
            nr = $urandom_range(0, 5);
            for (int i = 0; i < nr; i++) rd_data("data_random");
            wait_tx(nt);
            repeat (3 * DIV) tick();
            check("int_random", {31'd0, com_int}, {31'd0, m_ie && rx_model.size() != 0});
            rd_status("status_random", 1'b0, 1'b1);
        end
        while (rx_model.size() != 0) rd_data("data_drain");
        wr(2'd2, 32'd0);
        m_ie = 1'b0;

        // TX FIFO overflow: 4 queued + 1 in flight, 6th dropped
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            wr(2'd0, {24'd0, d});
            if (i < 5) tx_exp.push_back(d);
        end
        rd_status("status_tx_full", 1'b1, 1'b0);
        wait_tx(5);
        repeat (100) tick();
        check("tx_sixth_dropped", tx_got.size(), 0);
        rd_status("status_tx_drained", 1'b0, 1'b1);

        // Reset in the middle of a byte
        mon_en = 1'b0;
        wr(2'd0, 32'h0F);
        wr(2'd0, 32'hF0);
        t = 0;
        while (txd !== 1'b0 && t < 20) begin
            tick();
            t++;
        end
        repeat (2 * DIV) tick();
        rst = 1'b1;
        tick();
        check("txd_after_mid_rst", {31'd0, txd}, 32'd1);
        check("ready_after_mid_rst", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        rx_model.delete();
        m_fe = 1'b0; m_ovr = 1'b0;
        seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (txd !== 1'b1) seen_low = 1'b1;
        end
        check("txd_quiet_after_rst", {31'd0, seen_low}, 32'd0);
        rd_status("status_after_mid_rst", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
